// File: rtl/mimc_pkg.sv
// Shared definitions for the MiMC-BN254 round engine: field modulus,
// default operand width and the round FSM state encoding.
package mimc_pkg;

   localparam int MIMC_N_BITS = 254;

   localparam logic [253:0] BN254_P =
      254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

   typedef enum logic [2:0] {
      IDLE,
      ADD_K,
      ADD_C,
      SQ,
      SQ_GAP,
      CUBE,
      FIN
   } mimc_round_state_t;

endpackage

// File: rtl/galois_mult.sv
// Modular multiplier over GF(prime) using the Russian-peasant method:
// one multiplier bit per cycle, LSB first. The first enabled cycle loads
// the operands and already processes bit 0, so a product takes N_BITS
// clock edges and done rises N_BITS+1 cycles after en first goes high
// (counting the en cycle and the done cycle). done and product hold
// until the active-high reset clears the unit for the next job.
module galois_mult #(
   parameter int                  N_BITS = 254,
   parameter logic [N_BITS-1:0]   PRIME  = '1,
   parameter string               METHOD = "peasant"
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [N_BITS-1:0] num1,
   input  logic [N_BITS-1:0] num2,
   output logic [N_BITS-1:0] product,
   output logic              done
);

   localparam int CW = $clog2(N_BITS + 1);

   logic [N_BITS-1:0] addend;
   logic [N_BITS-1:0] multiplier_bits;
   logic [N_BITS-1:0] acc;
   logic [CW-1:0]     remaining;
   logic              running;

   if (METHOD != "peasant") begin : g_bad_method
      $error("galois_mult: only the peasant method is implemented");
   end

   function automatic logic [N_BITS-1:0] field_add(input logic [N_BITS-1:0] a,
                                                   input logic [N_BITS-1:0] b);
      logic [N_BITS:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, PRIME}) begin
         s = s - {1'b0, PRIME};
      end
      return s[N_BITS-1:0];
   endfunction

   // Shift-and-add iteration: acc accumulates addend for each set bit,
   // addend doubles mod prime each step.
   always_ff @(posedge clk) begin
      if (rst) begin
         addend          <= '0;
         multiplier_bits <= '0;
         acc             <= '0;
         remaining       <= '0;
         running         <= 1'b0;
         done            <= 1'b0;
      end else if (en && !done) begin
         if (!running) begin
            acc             <= num2[0] ? num1 : '0;
            addend          <= field_add(num1, num1);
            multiplier_bits <= num2 >> 1;
            remaining       <= CW'(N_BITS - 1);
            running         <= 1'b1;
         end else begin
            if (multiplier_bits[0]) begin
               acc <= field_add(acc, addend);
            end
            addend          <= field_add(addend, addend);
            multiplier_bits <= multiplier_bits >> 1;
            remaining       <= remaining - 1'b1;
            if (remaining == CW'(1)) begin
               running <= 1'b0;
               done    <= 1'b1;
            end
         end
      end
   end

   assign product = acc;

endmodule

// File: rtl/mimc_round_mod_add.sv
// Combinational modular adder: (a + b) mod prime for operands already
// reduced below prime. One conditional subtract is enough because the
// raw sum is always below 2*prime.
module mod_add #(
   parameter int                  N_BITS = 254,
   parameter logic [N_BITS-1:0]   PRIME  = '1
) (
   input  logic [N_BITS-1:0] a,
   input  logic [N_BITS-1:0] b,
   output logic [N_BITS-1:0] sum
);

   logic [N_BITS:0] raw;
   logic [N_BITS:0] reduced;

   // Widen by one bit so the carry is kept, then fold back into the field.
   always_comb begin
      raw     = {1'b0, a} + {1'b0, b};
      reduced = raw - {1'b0, PRIME};
      if (raw >= {1'b0, PRIME}) begin
         sum = reduced[N_BITS-1:0];
      end else begin
         sum = raw[N_BITS-1:0];
      end
   end

endmodule

// File: rtl/mimc_round.sv
// One MiMC-BN254 round: x_out = (x_in + key + round_const)^3 mod p.
// Two modular adds share one adder, then a single galois_mult instance
// is reused for the square and then the cube.
module mimc_round
   import mimc_pkg::*;
#(
   parameter int                  N_BITS             = MIMC_N_BITS,
   parameter logic [N_BITS-1:0]   PRIME              = BN254_P,
   parameter string               GALOIS_MULT_METHOD = "peasant"
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N_BITS-1:0] x_in,
   input  logic [N_BITS-1:0] key,
   input  logic [N_BITS-1:0] round_const,
   output logic              busy,
   output logic              done,
   output logic [N_BITS-1:0] x_out
);

   mimc_round_state_t state;
   mimc_round_state_t next_state;

   logic [N_BITS-1:0] x_r;
   logic [N_BITS-1:0] key_r;
   logic [N_BITS-1:0] c_r;
   logic [N_BITS-1:0] t;
   logic [N_BITS-1:0] t2;

   logic [N_BITS-1:0] add_a;
   logic [N_BITS-1:0] add_b;
   logic [N_BITS-1:0] add_sum;

   logic              mult_rst;
   logic              mult_en;
   logic [N_BITS-1:0] mult_num1;
   logic [N_BITS-1:0] mult_num2;
   logic [N_BITS-1:0] mult_product;
   logic              mult_done;

   logic              busy_next;
   logic              done_next;

   // The shared adder sees (x + key) in ADD_K and (t + c) otherwise.
   assign add_a = (state == ADD_K) ? x_r   : t;
   assign add_b = (state == ADD_K) ? key_r : c_r;

   mod_add #(
      .N_BITS (N_BITS),
      .PRIME  (PRIME)
   ) u_mod_add (
      .a   (add_a),
      .b   (add_b),
      .sum (add_sum)
   );

   // Square uses t*t, cube uses t2*t; t stays stable across both.
   assign mult_num1 = (state == CUBE) ? t2 : t;
   assign mult_num2 = t;

   galois_mult #(
      .N_BITS (N_BITS),
      .PRIME  (PRIME),
      .METHOD (GALOIS_MULT_METHOD)
   ) u_galois_mult (
      .clk     (clk),
      .rst     (mult_rst),
      .en      (mult_en),
      .num1    (mult_num1),
      .num2    (mult_num2),
      .product (mult_product),
      .done    (mult_done)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic and multiplier control; the multiplier runs only in
   // SQ and CUBE and is held in reset everywhere else, including SQ_GAP.
   always_comb begin
      next_state = state;
      mult_rst   = 1'b1;
      mult_en    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = ADD_K;
            end
         end
         ADD_K:  next_state = ADD_C;
         ADD_C:  next_state = SQ;
         SQ: begin
            mult_rst = 1'b0;
            mult_en  = 1'b1;
            if (mult_done) begin
               next_state = SQ_GAP;
            end
         end
         SQ_GAP: next_state = CUBE;
         CUBE: begin
            mult_rst = 1'b0;
            mult_en  = 1'b1;
            if (mult_done) begin
               next_state = FIN;
            end
         end
         FIN:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (!rst) begin
         mult_rst = 1'b1;
         mult_en  = 1'b0;
      end
   end

   // busy and done are registered copies decoded from the upcoming state.
   assign busy_next = (next_state != IDLE);
   assign done_next = (next_state == FIN);

   // Datapath: operand capture, the two adds, and product capture.
   always_ff @(posedge clk) begin
      if (!rst) begin
         x_r   <= '0;
         key_r <= '0;
         c_r   <= '0;
         t     <= '0;
         t2    <= '0;
         x_out <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         busy <= busy_next;
         done <= done_next;
         case (state)
            IDLE: begin
               if (start) begin
                  x_r   <= x_in;
                  key_r <= key;
                  c_r   <= round_const;
               end
            end
            ADD_K: t <= add_sum;
            ADD_C: t <= add_sum;
            SQ: begin
               if (mult_done) begin
                  t2 <= mult_product;
               end
            end
            CUBE: begin
               if (mult_done) begin
                  x_out <= mult_product;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mimc_round.md
# mimc_round

Single MiMC-BN254 round engine, sitting directly upstream of `galois_mult`: it feeds that multiplier its operands and consumes its products. It computes `x_out = (x_in + key + round_const)^3 mod p` over the BN254 scalar field using one internal `galois_mult` instance twice, square then cube. The MiMC hash top iterates this block once per round.

## Interface
Parameters:
- `N_BITS`, 254: operand/result width.
- `PRIME`, `254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001`: field modulus p.
- `GALOIS_MULT_METHOD`, "peasant": passed through to `galois_mult`.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset).
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `x_in`  in  N_BITS  round state; must be < p.
- `key`  in  N_BITS  MiMC key; must be < p.
- `round_const`  in  N_BITS  round constant; must be < p.
- `busy`  out  1  high from the cycle after an accepted start through FIN.
- `done`  out  1  one-cycle pulse; `x_out` is valid from this cycle onward.
- `x_out`  out  N_BITS  round result; holds until the next FIN.

## Operation
- Modular add, shared by ADD_K and ADD_C: `s = a + b` computed at N_BITS+1 bits; result is `s - p` if `s >= p`, else `s`.
- FSM states: IDLE, ADD_K, ADD_C, SQ, SQ_GAP, CUBE, FIN.
- IDLE: when `start=1`, latch `x_in`, `key`, `round_const` into internal registers and go to ADD_K.
- ADD_K: `t <= (x_r + key_r) mod p`; go to ADD_C.
- ADD_C: `t <= (t + c_r) mod p`; go to SQ.
- SQ: drive the multiplier with `num1=t`, `num2=t`, multiplier `rst=0`, `en=1`. On multiplier `done`, latch `t2 <= product` and go to SQ_GAP.
- SQ_GAP: hold the multiplier in reset for one cycle (`rst=1`, `en=0`) so it restarts cleanly; go to CUBE.
- CUBE: `num1=t2`, `num2=t`, multiplier `en=1`. On `done`, latch `x_out <= product` and go to FIN.
- FIN: `done=1` for one cycle; go to IDLE.
- Multiplier reset (active-high) is asserted in every state except SQ and CUBE.
- Operands must be < p; if they are not, the result is undefined, but the FSM still completes and returns to IDLE.

## Timing
- Reset (`rst=0` at an edge): state=IDLE; `busy=0`, `done=0`, `x_out=0`; internal `t`, `t2` and latched operands cleared; multiplier held in reset.
- Reset mid-operation aborts immediately: no `done` pulse, `x_out` cleared.
- Latency, `start` edge to `done`: 2 + Lm + 1 + Lm + 1 cycles.
  - Lm = cycles from multiplier `en` high to its `done` high.
- Inputs may change the cycle after `start` is accepted.
- `start` while `busy=1`, including in the FIN cycle, is ignored and not queued.
- Back-to-back operation: `start` asserted the cycle after `done` (IDLE) is accepted.
- `busy` and `done` are registered outputs.

## Structure
- Shared package `mimc_pkg`:
  - `BN254_P` constant.
  - FSM state enum `mimc_round_state_t`.
  - `N_BITS` default.
- One natural sub-module: `mod_add`, combinational, N_BITS+1-bit add with conditional subtract; used once and muxed between ADD_K and ADD_C.
- Instantiates the existing `galois_mult` with `N_BITS` and `GALOIS_MULT_METHOD` passed through.

## Test plan
- `x_in=2`, `key=0`, `round_const=1`, single `start` -> `done` after the stated latency; `x_out=27`.
- `x_in=p-1`, `key=1`, `round_const=0` (wrap to t=0) -> `x_out=0`.
- `x_in=p-1`, `key=0`, `round_const=0` -> `x_out=p-1`, since (-1)^3 = -1.
- `start` pulses during SQ and during FIN -> ignored; exactly one `done`; `x_out` matches the first operands.
- `rst=0` for one cycle during CUBE -> `busy=0`, `x_out=0`, no `done`. Then `start` with `x_in=3`, `key=0`, `round_const=0` -> `x_out=27`.
- Two back-to-back rounds, second `start` the cycle after the first `done`, random reduced operands -> both results match a golden model; latency identical for both.
